// File: rtl/handshake_pkg.sv
// Shared types and constants for the Pico link 4-phase handshake blocks.
// The receiver side imports the same width constant so both ends agree.
package handshake_pkg;

    // Link/FIFO word width used by both ends of the link
    localparam int DEFAULT_DATA_WIDTH = 4;

    // Cycles allowed per ACK edge: 20 ms at 50 MHz
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    // Transmit-side handshake states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_ACK_HI,
        WAIT_ACK_LO,
        RECOVER
    } tx_state_t;

endpackage

// File: rtl/handshake_tx_if.sv
// Pico link signal bundle: parallel data plus the REQ/ACK pair.
// The initiator drives data_out/req, the receiver answers with ack.
interface handshake_tx_if import handshake_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_out;
    logic                  req;
    logic                  ack;

    modport master (
        output data_out,
        output req,
        input  ack
    );

    modport slave (
        input  data_out,
        input  req,
        output ack
    );

endinterface

// File: rtl/handshake_tx_sync_fifo.sv
// Small synchronous FIFO with a registered read port.
// rd_data updates only on a pop, so the popped word stays put until the
// next pop. full/empty come straight from the registered occupancy.
module sync_fifo import handshake_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           count_reg;
    logic [AW:0]           count_next;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = rd_data_reg;
    assign level   = count_reg;

    // Occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - (AW+1)'(1);
        end
    end

    // Storage array write; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Registered read of the head word on pop
    always_ff @(posedge clk) begin
        if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/handshake_tx.sv
// Transmit end of the Pico 4-phase REQ/ACK link. Words queue in a FIFO
// and go out one at a time: data is presented, held for a setup delay,
// then REQ rises; ACK high drops REQ; ACK low completes the transfer.
// Each ACK edge is bounded by a timeout that discards the word.
module handshake_tx import handshake_pkg::*; #(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    handshake_tx_if.master              link,
    output logic                        busy,
    output logic                        sent_pulse,
    output logic                        timeout_err,
    input  logic                        clear_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int SCW = $clog2(SETUP_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] SETUP_LOAD   = SCW'(SETUP_CYCLES);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   ack_s;

    tx_state_t              state_reg, state_next;
    logic [SCW-1:0]         setup_cnt_reg, setup_cnt_next;
    logic [TCW-1:0]         tcnt_reg, tcnt_next;
    logic                   req_reg, req_next;
    logic [DATA_WIDTH-1:0]  data_out_reg, data_out_next;
    logic                   sent_reg, sent_next;
    logic                   err_reg, err_next;
    logic                   err_set;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready      = !fifo_full;
    assign ack_s         = ack_sync_reg[SYNC_STAGES-1];
    assign link.req      = req_reg;
    assign link.data_out = data_out_reg;
    assign sent_pulse    = sent_reg;
    assign timeout_err   = err_reg;
    assign busy          = (state_reg != IDLE) || !fifo_empty;

    // Synchroniser chain for the asynchronous ack
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], link.ack};
        end
    end

    // Handshake sequencing, setup delay, timeout and error flag update
    always_comb begin
        state_next     = state_reg;
        setup_cnt_next = setup_cnt_reg;
        tcnt_next      = tcnt_reg;
        req_next       = req_reg;
        data_out_next  = data_out_reg;
        sent_next      = 1'b0;
        err_set        = 1'b0;
        fifo_pop       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // A stale high ack blocks the next transfer
                if (!fifo_empty && !ack_s) begin
                    fifo_pop       = 1'b1;
                    setup_cnt_next = SETUP_LOAD;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                // The popped word is available from the FIFO one cycle later
                if (setup_cnt_reg == SETUP_LOAD) begin
                    data_out_next = fifo_rd_data;
                end
                if (setup_cnt_reg == '0) begin
                    req_next   = 1'b1;
                    tcnt_next  = '0;
                    state_next = WAIT_ACK_HI;
                end else begin
                    setup_cnt_next = setup_cnt_reg - SCW'(1);
                end
            end
            WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    tcnt_next  = '0;
                    state_next = WAIT_ACK_LO;
                end else if (tcnt_reg == TIMEOUT_LAST) begin
                    req_next   = 1'b0;
                    err_set    = 1'b1;
                    state_next = RECOVER;
                end else begin
                    tcnt_next = tcnt_reg + TCW'(1);
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_s) begin
                    sent_next  = 1'b1;
                    state_next = IDLE;
                end else if (tcnt_reg == TIMEOUT_LAST) begin
                    err_set    = 1'b1;
                    state_next = RECOVER;
                end else begin
                    tcnt_next = tcnt_reg + TCW'(1);
                end
            end
            RECOVER: begin
                // Timed-out word is dropped; just wait for the link to settle
                req_next = 1'b0;
                if (!ack_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new timeout beats a simultaneous clear
        if (err_set) begin
            err_next = 1'b1;
        end else if (clear_err) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            setup_cnt_reg <= '0;
            tcnt_reg      <= '0;
            req_reg       <= 1'b0;
            data_out_reg  <= '0;
            sent_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            setup_cnt_reg <= setup_cnt_next;
            tcnt_reg      <= tcnt_next;
            req_reg       <= req_next;
            data_out_reg  <= data_out_next;
            sent_reg      <= sent_next;
            err_reg       <= err_next;
        end
    end

endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx: single transfer, burst with back-pressure,
// stale ack, timeout with recovery, timeout/clear collision and mid-transfer reset.
module tb_handshake_tx;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          busy;
    logic          sent_pulse;
    logic          timeout_err;
    logic          clear_err;
    logic [2:0]    fifo_level;

    // Receiver model: ack follows req three cycles later unless forced
    logic          rx_auto;
    logic          ack_force;
    logic [2:0]    req_dly;
    int            sent_count = 0;
    logic          data_moved = 1'b0;
    logic [DW-1:0] data_held = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int c;

    handshake_tx_if #(.DATA_WIDTH(DW)) lnk ();

    handshake_tx #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (4),
        .SETUP_CYCLES   (2),
        .TIMEOUT_CYCLES (16),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .link        (lnk),
        .busy        (busy),
        .sent_pulse  (sent_pulse),
        .timeout_err (timeout_err),
        .clear_err   (clear_err),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    assign lnk.ack = rx_auto ? req_dly[2] : ack_force;

    always @(posedge clk) begin
        if (reset) req_dly <= '0;
        else       req_dly <= {req_dly[1:0], lnk.req};
        if (sent_pulse) sent_count <= sent_count + 1;
        if (!reset && lnk.req && (lnk.data_out !== data_held)) data_moved <= 1'b1;
        data_held <= lnk.data_out;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [DW-1:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Ticks until req (use_req) or sent_pulse equals val; -1 if the budget expires
    task automatic wait_sig(input bit use_req, input logic val, input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((use_req ? lnk.req : sent_pulse) === val) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        clear_err = 1'b0;
        rx_auto   = 1'b1;
        ack_force = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_req",        lnk.req, 0);
        check("rst_data_out",   lnk.data_out, 0);
        check("rst_sent",       sent_pulse, 0);
        check("rst_err",        timeout_err, 0);
        check("rst_busy",       busy, 0);
        check("rst_level",      fifo_level, 0);
        check("rst_in_ready",   in_ready, 1);

        // Single word: data at N+2, req at N+4, sent 12 cycles after req
        push(4'hA);
        check("t1_level_push",  fifo_level, 1);
        check("t1_busy",        busy, 1);
        tick();
        check("t1_level_pop",   fifo_level, 0);
        check("t1_data_n1",     lnk.data_out, 0);
        tick();
        check("t1_data_n2",     lnk.data_out, 4'hA);
        check("t1_req_n2",      lnk.req, 0);
        tick();
        check("t1_req_n3",      lnk.req, 0);
        tick();
        check("t1_req_n4",      lnk.req, 1);
        wait_sig(1'b0, 1'b1, 40, c);
        check("t1_sent_delay",  c, 12);
        check("t1_req_end",     lnk.req, 0);
        check("t1_busy_end",    busy, 0);
        tick();
        check("t1_sent_once",   sent_pulse, 0);
        check("t1_level_end",   fifo_level, 0);

        // Burst: stale ack holds the FIFO so it fills, then drains 1..5 in order
        rx_auto   = 1'b0;
        ack_force = 1'b1;
        repeat (3) tick();
        push(4'h1);
        push(4'h2);
        push(4'h3);
        push(4'h4);
        check("b_level_full",   fifo_level, 4);
        check("b_ready_full",   in_ready, 0);
        in_data  = 4'h5;
        in_valid = 1'b1;
        repeat (3) tick();
        check("b_level_held",   fifo_level, 4);
        check("b_ready_held",   in_ready, 0);
        rx_auto = 1'b1;
        c = -1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                c = i;
                break;
            end
            tick();
        end
        check("b_ready_freed",  c, 3);
        tick();
        in_valid = 1'b0;
        check("b_level_5th",    fifo_level, 4);
        for (int k = 1; k <= 5; k++) begin
            wait_sig(1'b0, 1'b1, 60, c);
            check("b_sent_found", (c != -1), 1);
            check("b_word_order", lnk.data_out, k);
        end
        tick();
        check("b_level_end",    fifo_level, 0);
        check("b_busy_end",     busy, 0);

        // Stale ack: nothing moves until ack is released
        rx_auto   = 1'b0;
        ack_force = 1'b1;
        repeat (3) tick();
        push(4'h7);
        repeat (8) tick();
        check("s_req_blocked",  lnk.req, 0);
        check("s_level",        fifo_level, 1);
        rx_auto = 1'b1;
        wait_sig(1'b0, 1'b1, 60, c);
        check("s_sent_found",   (c != -1), 1);
        check("s_word",         lnk.data_out, 4'h7);

        // Timeout: receiver silent, word 8 dropped, word 9 goes through
        rx_auto   = 1'b0;
        ack_force = 1'b0;
        tick();
        push(4'h8);
        push(4'h9);
        check("to_level_pushpop", fifo_level, 1);
        wait_sig(1'b1, 1'b1, 20, c);
        check("to_req_rise",    (c != -1), 1);
        check("to_data",        lnk.data_out, 4'h8);
        wait_sig(1'b1, 1'b0, 40, c);
        check("to_req_width",   c, 16);
        check("to_err_set",     timeout_err, 1);
        rx_auto = 1'b1;
        wait_sig(1'b0, 1'b1, 80, c);
        check("to_next_sent",   (c != -1), 1);
        check("to_next_word",   lnk.data_out, 4'h9);
        check("to_err_sticky",  timeout_err, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_err_cleared", timeout_err, 0);

        // Timeout and clear_err on the same edge: set wins
        rx_auto = 1'b0;
        push(4'hB);
        wait_sig(1'b1, 1'b1, 20, c);
        check("tc_req_rise",    (c != -1), 1);
        repeat (15) tick();
        check("tc_err_before",  timeout_err, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("tc_err_wins",    timeout_err, 1);
        check("tc_req_drop",    lnk.req, 0);
        rx_auto = 1'b1;
        repeat (10) tick();
        check("tc_idle",        busy, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("tc_err_clear",   timeout_err, 0);

        // Reset while in WAIT_ACK_LO aborts the transfer and empties the FIFO
        push(4'hC);
        push(4'hD);
        wait_sig(1'b1, 1'b1, 20, c);
        check("rm_req_rise",    (c != -1), 1);
        wait_sig(1'b1, 1'b0, 20, c);
        check("rm_req_fall",    c, 6);
        reset = 1'b1;
        tick();
        check("rm_req",         lnk.req, 0);
        check("rm_data_out",    lnk.data_out, 0);
        check("rm_level",       fifo_level, 0);
        reset = 1'b0;
        tick();
        check("rm_in_ready",    in_ready, 1);
        check("rm_busy",        busy, 0);
        repeat (15) tick();
        check("total_sent",     sent_count, 8);
        check("data_stable",    data_moved, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/handshake_tx.md
Name: handshake_tx

Overview:
- Transmit end of the 4-phase REQ/ACK parallel handshake used on the Pico link; this block is the initiator that drives DATA/REQ and consumes ACK from a remote receiver.
- Local logic pushes words into a small FIFO. The block serialises them onto the link one transfer at a time.
- Provides ACK synchronisation, a data setup delay before REQ, timeout detection with recovery, and status outputs for the top level and LEDs.

Parameters:
- DATA_WIDTH, 4, width of link data and FIFO words
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
- SETUP_CYCLES, 2, cycles data_out is stable before req rises; >= 1
- TIMEOUT_CYCLES, 1_000_000, max cycles waiting for each ACK edge (20 ms at 50 MHz)
- SYNC_STAGES, 2, flops in the ack synchroniser; >= 2

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH  word to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; a write occurs on in_valid && in_ready
- data_out  out  DATA_WIDTH  link data to receiver
- req  out  1  link request
- ack  in  1  link acknowledge, asynchronous
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- sent_pulse  out  1  one-cycle pulse per completed 4-phase transfer
- timeout_err  out  1  sticky error flag
- clear_err  in  1  one-cycle clear of timeout_err
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: req=0, data_out=0, sent_pulse=0, timeout_err=0, busy=0, fifo_level=0, in_ready=1 after the reset cycle. The FIFO is emptied, the FSM enters IDLE and the synchroniser flops clear to 0.
- Reset asserted mid-transfer aborts immediately. req drops on the next edge and the in-flight word is lost.
- ack passes through SYNC_STAGES flops to form ack_s. All FSM decisions use ack_s only.
- FIFO:
  - in_ready = !full, registered from occupancy. There is no write-through bypass.
  - A simultaneous push and pop when not full changes fifo_level by 0.
  - When full, in_ready=0 even if a pop occurs the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states, with transitions evaluated each clock:
  - IDLE: if FIFO non-empty and ack_s==0, pop the head into data_out, load the setup counter and go to SETUP. If ack_s==1 (stale ACK), remain in IDLE.
  - SETUP: count SETUP_CYCLES. At terminal count set req<=1, clear the timeout counter and go to WAIT_ACK_HI.
  - WAIT_ACK_HI: if ack_s==1, set req<=0, clear the timeout counter and go to WAIT_ACK_LO. If the timeout counter reaches TIMEOUT_CYCLES-1, set req<=0, timeout_err<=1 and go to RECOVER.
  - WAIT_ACK_LO: if ack_s==0, assert sent_pulse for 1 cycle and go to IDLE. On timeout, set timeout_err<=1 and go to RECOVER.
  - RECOVER: req=0. Wait for ack_s==0, then go to IDLE. The word that timed out is discarded, not retried. No sent_pulse is issued for it.
- data_out holds the last transmitted word until the next pop. It never changes while req==1.
- Latency: a word accepted at edge N into an empty FIFO with idle link gives data_out valid at edge N+2 and req high at edge N+2+SETUP_CYCLES.
- Back-to-back transfers need at least 1 IDLE cycle between sent_pulse and the next pop.
- timeout_err:
  - Set by a timeout and held until clear_err.
  - If a timeout and clear_err occur in the same cycle, set wins.
  - Transfers continue while the flag is set.
- Timeout counter saturates; it never wraps.

Decomposition:
- Package handshake_pkg:
  - tx_state_t enum {IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO, RECOVER}
  - DEFAULT_DATA_WIDTH = 4
  - DEFAULT_TIMEOUT_CYCLES
  - The receiver FSM imports the same width constant.
- One sub-module, sync_fifo (params DATA_WIDTH, DEPTH; push/pop/full/empty/level). Synchroniser and FSM stay inline.

Test Plan:
- Single word: push 4'hA with a looping-back receiver model (ack follows req after 3 cycles) -> data_out=4'hA stable SETUP_CYCLES before req rises, one sent_pulse, req=0 at end, fifo_level back to 0.
- Burst: push 4'h1, 4'h2, 4'h3, 4'h4, 4'h5 back-to-back -> in_ready=0 after the 4th push, 5th held until a pop frees space, words appear on data_out in order 1..5, 5 sent_pulses.
- Timeout: ack stuck at 0 with TIMEOUT_CYCLES=16 -> req drops 16 cycles after rising, timeout_err=1, word discarded, next queued word transmits normally; clear_err then clears the flag.
- Stale ACK: hold ack=1 from reset, push 4'h7 -> req stays 0 until ack released, then the transfer completes.
- Reset mid-transfer: assert reset during WAIT_ACK_LO -> next cycle req=0, data_out=0, fifo_level=0, in_ready=1 after release.
- Simultaneous timeout and clear_err in the same cycle -> timeout_err=1.
